// File: rtl/ps2_host_pkg.sv
// Shared definitions for the PS/2 mouse host: sequencer states, device
// response codes and the initialisation command list.
package ps2_host_pkg;

  typedef enum logic [2:0] {
    SEND       = 3'd0,
    WAIT_ACK   = 3'd1,
    WAIT_BAT   = 3'd2,
    WAIT_ID0   = 3'd3,
    WAIT_DEVID = 3'd4,
    STREAM     = 3'd5,
    FAIL       = 3'd6
  } state_t;

  // Device responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_ERR  = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] DEV_ID_STD   = 8'h00;
  localparam logic [7:0] DEV_ID_WHEEL = 8'h03;

  // Positions in the init list that trigger special follow-up handling
  localparam int         INIT_LEN   = 9;
  localparam logic [3:0] IDX_RESET  = 4'd0;  // FF: followed by AA, 00
  localparam logic [3:0] IDX_GET_ID = 4'd7;  // F2: followed by device ID
  localparam logic [3:0] IDX_ENABLE = 4'd8;  // F4: last command, then stream

  // Reset, the 200/100/80 sample-rate knock that unlocks the wheel,
  // read ID, enable data reporting.
  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    case (i)
      4'd0:    return 8'hFF;
      4'd1:    return 8'hF3;
      4'd2:    return 8'hC8;
      4'd3:    return 8'hF3;
      4'd4:    return 8'h64;
      4'd5:    return 8'hF3;
      4'd6:    return 8'h50;
      4'd7:    return 8'hF2;
      4'd8:    return 8'hF4;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ps2_pkt_assembler.sv
// Collects stream-mode bytes into 3- or 4-byte mouse packets, resyncing on
// a byte 0 without the always-one bit 3, on receive errors and on long gaps.
module ps2_pkt_assembler
  import ps2_host_pkg::*;
#(
  parameter int GAP_CYCLES = 50000,
  parameter int TW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wheel,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_err,
  input  logic [TW-1:0] timer,
  output logic [31:0]   pkt,
  output logic          pkt_valid
);

  logic [1:0] cnt;
  logic [1:0] eff_cnt;
  logic [1:0] last;
  logic       gap_hit;
  logic       take;
  logic [7:0] b0, b1, b2;

  // A partial packet that has sat idle too long is abandoned; a byte that
  // arrives right at the limit is treated as the first of a new packet.
  assign gap_hit = (cnt != 2'd0) && (timer >= TW'(GAP_CYCLES));
  assign eff_cnt = gap_hit ? 2'd0 : cnt;
  assign last    = wheel ? 2'd3 : 2'd2;
  assign take    = en && rx_valid && !rx_err && ((eff_cnt != 2'd0) || rx_data[3]);

  // Byte counter, packet output register and completion strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 2'd0;
      pkt       <= 32'h0;
      pkt_valid <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      if (!en || (rx_valid && rx_err)) begin
        cnt <= 2'd0;
      end else if (take) begin
        if (eff_cnt == last) begin
          pkt       <= wheel ? {rx_data, b2, b1, b0} : {8'h00, rx_data, b1, b0};
          pkt_valid <= 1'b1;
          cnt       <= 2'd0;
        end else begin
          cnt <= eff_cnt + 2'd1;
        end
      end else if (rx_valid || gap_hit) begin
        cnt <= 2'd0;
      end
    end
  end

  // Leading byte holding registers; only meaningful while cnt says so
  always_ff @(posedge clk) begin
    if (take) begin
      case (eff_cnt)
        2'd0:    b0 <= rx_data;
        2'd1:    b1 <= rx_data;
        2'd2:    b2 <= rx_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse host sequencer: runs the wheel-detect init sequence over a
// byte-level PHY with ack/resend/timeout handling, then hands received
// bytes to the packet assembler.
module ps2_mouse_sequencer
  import ps2_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int BAT_CYCLES     = 25000000,
  parameter int GAP_CYCLES     = 50000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  input  logic        restart,
  output logic [31:0] pkt,
  output logic        pkt_valid,
  output logic        wheel_present,
  output logic        init_done,
  output logic        init_fail
);

  // One timer serves response, self-test and packet-gap timing
  localparam int TMAX_A = (TIMEOUT_CYCLES > BAT_CYCLES) ? TIMEOUT_CYCLES : BAT_CYCLES;
  localparam int TMAX   = (TMAX_A > GAP_CYCLES) ? TMAX_A : GAP_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int RW     = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  state_t        state;
  logic [3:0]    idx;
  logic [RW-1:0] retry;
  logic [TW-1:0] timer;

  logic          tmo_resp;
  logic          tmo_bat;
  logic          err_ev;
  logic          resend_ev;
  logic          retry_full;
  logic [3:0]    retry_idx;
  logic [3:0]    idx_next;

  assign tmo_resp   = (timer >= TW'(TIMEOUT_CYCLES));
  assign tmo_bat    = (timer >= TW'(BAT_CYCLES));
  assign retry_full = (retry >= RW'(MAX_RETRY - 1));
  assign retry_idx  = resend_ev ? idx : IDX_RESET;
  assign idx_next   = idx + 4'd1;

  // Classify this cycle's response: resend request, or a failure that
  // restarts the sequence from the reset command. A byte arriving in the
  // same cycle as a timeout takes precedence over the timeout.
  always_comb begin
    err_ev    = 1'b0;
    resend_ev = 1'b0;
    case (state)
      WAIT_ACK: begin
        if (rx_valid) begin
          if (rx_err)                      err_ev    = 1'b1;
          else if (rx_data == RSP_RESEND)  resend_ev = 1'b1;
          else if (rx_data != RSP_ACK)     err_ev    = 1'b1;
        end else begin
          err_ev = tmo_resp;
        end
      end
      WAIT_BAT: begin
        if (rx_valid) err_ev = rx_err || (rx_data == RSP_BAT_ERR) || (rx_data != RSP_BAT_OK);
        else          err_ev = tmo_bat;
      end
      WAIT_ID0: begin
        if (rx_valid) err_ev = rx_err || (rx_data != DEV_ID_STD);
        else          err_ev = tmo_resp;
      end
      WAIT_DEVID: begin
        if (rx_valid) err_ev = rx_err || ((rx_data != DEV_ID_STD) && (rx_data != DEV_ID_WHEEL));
        else          err_ev = tmo_resp;
      end
      default: ;
    endcase
  end

  // Init sequencer with registered PHY handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEND;
      idx           <= IDX_RESET;
      retry         <= '0;
      timer         <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      init_done     <= 1'b0;
      init_fail     <= 1'b0;
      wheel_present <= 1'b0;
    end else if (restart) begin
      // tx_valid goes straight to 1 so a pending offer never drops
      state         <= SEND;
      idx           <= IDX_RESET;
      retry         <= '0;
      timer         <= '0;
      tx_valid      <= 1'b1;
      tx_data       <= init_cmd(IDX_RESET);
      init_done     <= 1'b0;
      init_fail     <= 1'b0;
      wheel_present <= 1'b0;
    end else begin
      if (rx_valid && (state != SEND)) timer <= '0;
      else if (timer != '1)            timer <= timer + 1'b1;

      if (err_ev || resend_ev) begin
        timer <= '0;
        if (retry_full) begin
          state     <= FAIL;
          tx_valid  <= 1'b0;
          init_fail <= 1'b1;
        end else begin
          retry    <= retry + 1'b1;
          idx      <= retry_idx;
          state    <= SEND;
          tx_valid <= 1'b1;
          tx_data  <= init_cmd(retry_idx);
        end
      end else begin
        case (state)
          SEND: begin
            tx_valid <= 1'b1;
            tx_data  <= init_cmd(idx);
            if (tx_valid && tx_ready) begin
              state    <= WAIT_ACK;
              tx_valid <= 1'b0;
              timer    <= '0;
            end
          end
          WAIT_ACK: begin
            if (rx_valid) begin
              if (idx == IDX_RESET) begin
                state <= WAIT_BAT;
              end else if (idx == IDX_GET_ID) begin
                state <= WAIT_DEVID;
              end else if (idx == IDX_ENABLE) begin
                state     <= STREAM;
                init_done <= 1'b1;
              end else begin
                idx      <= idx_next;
                state    <= SEND;
                tx_valid <= 1'b1;
                tx_data  <= init_cmd(idx_next);
              end
            end
          end
          WAIT_BAT: begin
            if (rx_valid) state <= WAIT_ID0;
          end
          WAIT_ID0: begin
            if (rx_valid) begin
              idx      <= 4'd1;
              state    <= SEND;
              tx_valid <= 1'b1;
              tx_data  <= init_cmd(4'd1);
            end
          end
          WAIT_DEVID: begin
            if (rx_valid) begin
              wheel_present <= (rx_data == DEV_ID_WHEEL);
              idx           <= IDX_ENABLE;
              state         <= SEND;
              tx_valid      <= 1'b1;
              tx_data       <= init_cmd(IDX_ENABLE);
            end
          end
          STREAM: ;
          FAIL: begin
            tx_valid <= 1'b0;
          end
          default: begin
            state <= SEND;
          end
        endcase
      end
    end
  end

  ps2_pkt_assembler #(
    .GAP_CYCLES (GAP_CYCLES),
    .TW         (TW)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .en        (state == STREAM),
    .wheel     (wheel_present),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .timer     (timer),
    .pkt       (pkt),
    .pkt_valid (pkt_valid)
  );

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Randomized scoreboard bench for ps2_mouse_sequencer: a PHY/mouse model
// drives responses, expected commands and packets are queued, and a
// monitor compares whatever the DUT presents.
module tb_ps2_mouse_sequencer;

  localparam int T_TO    = 60;
  localparam int T_BAT   = 100;
  localparam int T_GAP   = 20;
  localparam int N_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] pkt;
  logic        pkt_valid;
  logic        wheel_present;
  logic        init_done;
  logic        init_fail;

  ps2_mouse_sequencer #(
    .TIMEOUT_CYCLES (T_TO),
    .BAT_CYCLES     (T_BAT),
    .GAP_CYCLES     (T_GAP),
    .MAX_RETRY      (N_RETRY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_err        (rx_err),
    .restart       (restart),
    .pkt           (pkt),
    .pkt_valid     (pkt_valid),
    .wheel_present (wheel_present),
    .init_done     (init_done),
    .init_fail     (init_fail)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_count = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int rdy_mode = 0;  // 0 low, 1 random, 2 high
  bit cur_wheel = 1'b0;

  logic [7:0]  cmds [9] = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
  logic [7:0]  exp_cmd [$];
  logic [31:0] exp_pkt [$];
  logic [7:0]  part [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // PHY ready driver, updated mid-cycle
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b1;
    endcase
  end

  // Monitor: every accepted command and every packet strobe is scored
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        hs_count++;
        last_hs_cyc = cyc;
        if (exp_cmd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cmd_unexpected: got %h, expected no command", tx_data);
        end else begin
          chk("cmd", {24'h0, tx_data}, {24'h0, exp_cmd.pop_front()});
        end
      end
      if (pkt_valid) begin
        if (exp_pkt.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pkt_unexpected: got %h, expected no packet", pkt);
        end else begin
          chk("pkt", pkt, exp_pkt.pop_front());
        end
      end
    end
  end

  task automatic wait_hs();
    int start = hs_count;
    int k = 0;
    while (hs_count == start && k < 2000) begin
      tick(1);
      k++;
    end
    if (hs_count == start) begin
      n_tests++;
      n_fail++;
      $display("FAIL hs_timeout: got no command in %0d cycles, expected one", k);
    end
  endtask

  task automatic rx_byte(input logic [7:0] d, input bit e);
    rx_data  = d;
    rx_err   = e;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  // Mouse side of the init dialogue; fe_idx selects one command to NAK once
  task automatic do_init(input bit wheel, input int fe_idx);
    rdy_mode = 1;
    part.delete();
    for (int i = 0; i < 9; i++) begin
      exp_cmd.push_back(cmds[i]);
      wait_hs();
      tick($urandom_range(0, 4));
      if (i == fe_idx) begin
        rx_byte(8'hFE, 1'b0);
        exp_cmd.push_back(cmds[i]);
        wait_hs();
        tick($urandom_range(0, 4));
      end
      rx_byte(8'hFA, 1'b0);
      if (i == 0) begin
        tick($urandom_range(0, 5));
        rx_byte(8'hAA, 1'b0);
        tick($urandom_range(0, 5));
        rx_byte(8'h00, 1'b0);
      end
      if (i == 7) begin
        tick($urandom_range(0, 5));
        rx_byte(wheel ? 8'h03 : 8'h00, 1'b0);
      end
    end
    cur_wheel = wheel;
    tick(1);
    chk("init_done", {31'h0, init_done}, 32'h1);
    chk("wheel_present", {31'h0, wheel_present}, {31'h0, wheel});
    chk("init_fail_clear", {31'h0, init_fail}, 32'h0);
  endtask

  // Packet rules applied to the byte stream, then the byte is driven
  task automatic stream_byte(input logic [7:0] b, input bit err, input bit big_gap);
    int n = cur_wheel ? 4 : 3;
    if (big_gap) begin
      part.delete();
      tick(2 * T_GAP + 3);
    end else begin
      tick($urandom_range(0, 3));
    end
    if (err) begin
      part.delete();
    end else if (part.size() != 0 || b[3]) begin
      part.push_back(b);
      if (part.size() == n) begin
        exp_pkt.push_back({(n == 4) ? part[3] : 8'h00, part[2], part[1], part[0]});
        part.delete();
      end
    end
    rx_byte(b, err);
  endtask

  task automatic stream_rand(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      int kind = $urandom_range(0, 15);
      logic [7:0] b = 8'($urandom);
      if ($urandom_range(0, 3) != 0) b[3] = 1'b1;
      stream_byte(b, kind == 1, kind == 0);
    end
    tick(2 * T_GAP + 3);
    part.delete();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
    chk({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    chk({tag, "_pkt_valid"}, {31'h0, pkt_valid}, 32'h0);
    chk({tag, "_pkt"}, pkt, 32'h0);
    chk({tag, "_init_done"}, {31'h0, init_done}, 32'h0);
    chk({tag, "_init_fail"}, {31'h0, init_fail}, 32'h0);
    chk({tag, "_wheel"}, {31'h0, wheel_present}, 32'h0);
  endtask

  initial begin
    int t1, t2, t3, k;

    // Reset state and first offer after release
    tick(3);
    chk_reset_outputs("rst0");
    rst = 1'b0;
    tick(1);
    chk("first_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("first_tx_data", {24'h0, tx_data}, 32'hFF);

    // Nominal init with wheel, then directed and random stream
    do_init(1'b1, -1);
    stream_byte(8'h00, 1'b0, 1'b0);
    stream_byte(8'h09, 1'b0, 1'b0);
    stream_byte(8'h05, 1'b0, 1'b0);
    stream_byte(8'hFB, 1'b0, 1'b0);
    stream_byte(8'h01, 1'b0, 1'b0);
    tick(2);
    chk("pkt_wheel_directed", pkt, 32'h01FB0509);
    stream_rand(40);

    // Asynchronous reset in the middle of stream mode
    rdy_mode = 0;
    stream_byte(8'h08, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_stream");
    part.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_rel_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("rst_rel_tx_data", {24'h0, tx_data}, 32'hFF);

    // Init with one resend of 0x64 and a standard (no-wheel) device ID
    do_init(1'b0, 4);
    stream_byte(8'h08, 1'b0, 1'b0);
    stream_byte(8'h10, 1'b0, 1'b0);
    stream_byte(8'h20, 1'b0, 1'b0);
    tick(2);
    chk("pkt_std_directed", pkt, 32'h00201008);
    stream_rand(30);

    // Restart from stream, then let every FF time out
    rdy_mode = 0;
    tick(1);
    pulse_restart();
    chk("rs_init_done", {31'h0, init_done}, 32'h0);
    chk("rs_init_fail", {31'h0, init_fail}, 32'h0);
    chk("rs_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("rs_tx_data", {24'h0, tx_data}, 32'hFF);
    repeat (N_RETRY) exp_cmd.push_back(8'hFF);
    rdy_mode = 2;
    wait_hs();
    t1 = last_hs_cyc;
    wait_hs();
    t2 = last_hs_cyc;
    wait_hs();
    t3 = last_hs_cyc;
    chk("timeout_gap1", {31'h0, 1'((t2 - t1) >= T_TO && (t2 - t1) <= T_TO + 4)}, 32'h1);
    chk("timeout_gap2", {31'h0, 1'((t3 - t2) >= T_TO && (t3 - t2) <= T_TO + 4)}, 32'h1);
    k = 0;
    while (!init_fail && k < T_TO + 20) begin
      tick(1);
      k++;
    end
    chk("fail_init_fail", {31'h0, init_fail}, 32'h1);
    chk("fail_tx_valid", {31'h0, tx_valid}, 32'h0);
    tick(3 * T_TO);
    chk("fail_held", {31'h0, init_fail}, 32'h1);
    chk("fail_held_tx", {31'h0, tx_valid}, 32'h0);

    // Restart out of FAIL
    rdy_mode = 0;
    pulse_restart();
    chk("rf_init_fail", {31'h0, init_fail}, 32'h0);
    chk("rf_init_done", {31'h0, init_done}, 32'h0);
    chk("rf_wheel", {31'h0, wheel_present}, 32'h0);
    chk("rf_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("rf_tx_data", {24'h0, tx_data}, 32'hFF);

    // Restart while F3 is being offered and not yet accepted
    exp_cmd.push_back(8'hFF);
    rdy_mode = 2;
    wait_hs();
    tick(1);
    rx_byte(8'hFA, 1'b0);
    rdy_mode = 0;
    tick(2);
    rx_byte(8'hAA, 1'b0);
    tick(2);
    rx_byte(8'h00, 1'b0);
    tick(3);
    chk("pend_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("pend_tx_data", {24'h0, tx_data}, 32'hF3);
    pulse_restart();
    for (int i = 0; i < 3; i++) begin
      chk("pend_rs_tx_valid", {31'h0, tx_valid}, 32'h1);
      chk("pend_rs_tx_data", {24'h0, tx_data}, 32'hFF);
      tick(1);
    end

    // Randomized full init and stream
    do_init(1'($urandom_range(0, 1)), $urandom_range(0, 8));
    stream_rand(40);

    tick(5);
    chk("cmd_queue_drained", exp_cmd.size(), 32'h0);
    chk("pkt_queue_drained", exp_pkt.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
